counter_seq_ctrl: RTL and testbench

Command-driven sequencer for a small modulo up-counter datapath. Accepts a run command with terminal count and loop count, then runs the counter for that many full wraps. Supports pause and abort, and reports wrap and completion pulses. Sits between control logic and the counter; the counter datapath is its only sub-module.

---
 rtl/counter_seq_pkg.sv | 22 ++
 rtl/counter_seq_ctrl_if.sv | 34 +++
 rtl/counter_seq_ctrl_mod_counter.sv | 67 ++++++
 rtl/counter_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg
// Shared definitions for the counter sequencer slice: default widths, FSM
// state encoding and a small state-decode helper.
// Optional build macro used by the slice: COUNTER_SEQ_DOWN_EN (down-count mode).
package counter_seq_pkg;

  localparam int CNT_W_DEF  = 2;
  localparam int LOOP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // busy covers both the counting and the paused state
  function automatic logic is_busy(input state_e st);
    return (st == ST_RUN) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if
// Command handshake bundle between a requester (master) and the sequencer
// (slave).
//   cmd_valid  : command offered by the master
//   cmd_ready  : sequencer can accept (idle)
//   cmd_limit  : inclusive terminal count
//   cmd_loops  : number of full wraps to run
//   cmd_dir    : count direction, 1 = down (only with COUNTER_SEQ_DOWN_EN)
interface counter_seq_ctrl_if
  import counter_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LOOP_W = LOOP_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CNT_W-1:0]  cmd_limit;
  logic [LOOP_W-1:0] cmd_loops;
`ifdef COUNTER_SEQ_DOWN_EN
  logic              cmd_dir;

  modport master (output cmd_valid, output cmd_limit, output cmd_loops,
                  output cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_limit, input cmd_loops,
                  input cmd_dir, output cmd_ready);
`else
  modport master (output cmd_valid, output cmd_limit, output cmd_loops,
                  input cmd_ready);
  modport slave  (input cmd_valid, input cmd_limit, input cmd_loops,
                  output cmd_ready);
`endif

endinterface

// File: rtl/counter_seq_ctrl_mod_counter.sv
// mod_counter
// Modulo counter datapath owned by the sequencer.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : force cnt to 0 (beats load and en)
//   load      : load cnt with load_val
//   load_val  : value loaded on load
//   en        : advance one step this cycle
//   dir       : 0 = up (0..limit), 1 = down (limit..0)
//   limit     : inclusive terminal / reload value
//   cnt       : registered counter value
//   at_term   : cnt sits on the terminal value for the current direction
module mod_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             at_term_s;

  // terminal detect: top of range counting up, zero counting down
  always_comb begin
    at_term_s = 1'b0;
    if (dir) begin
      at_term_s = (cnt_r == ZERO);
    end else begin
      at_term_s = (cnt_r == limit);
    end
  end

  // counter register: clear > load > step; a wrap restarts from the start value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= ZERO;
    end else if (clear) begin
      cnt_r <= ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en) begin
      if (at_term_s) begin
        cnt_r <= dir ? limit : ZERO;
      end else if (dir) begin
        cnt_r <= cnt_r - ONE;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign at_term = at_term_s;

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Command-driven sequencer: accepts (limit, loops), runs mod_counter for
// that many full wraps, supports pause (level) and abort, and pulses wrap on
// each return to the start value and done on normal completion.
//   clk, rst : clock, synchronous active-high reset
//   cmd_if   : command handshake (slave side)
//   pause    : level, freezes the counter while high
//   abort    : cancels the current run, back to idle without done
//   cnt      : registered counter value
//   busy     : counting or paused
//   wrap     : one-cycle pulse when cnt returns to its start value
//   done     : one-cycle pulse on normal completion
// Build option COUNTER_SEQ_DOWN_EN adds cmd_dir (down-counting runs).
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LOOP_W = LOOP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  counter_seq_ctrl_if.slave  cmd_if,
  input  logic               pause,
  input  logic               abort,
  output logic [CNT_W-1:0]   cnt,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [LOOP_W-1:0] LOOP_ZERO = {LOOP_W{1'b0}};
  localparam logic [LOOP_W-1:0] LOOP_ONE  = LOOP_W'(1);

  state_e            state_r, state_nx;
  logic [LOOP_W-1:0] loops_r, loops_nx;
  logic [CNT_W-1:0]  limit_r, limit_nx;
  logic              dir_r, dir_nx;
  logic              wrap_r, wrap_nx;
  logic              done_r, done_nx;
  logic              clr_s, load_s, en_s, at_term_s, cmd_dir_s;
  logic [CNT_W-1:0]  load_val_s;

`ifdef COUNTER_SEQ_DOWN_EN
  assign cmd_dir_s = cmd_if.cmd_dir;
`else
  assign cmd_dir_s = 1'b0;
`endif

  // next-state, loop bookkeeping and counter controls
  always_comb begin
    state_nx   = state_r;
    loops_nx   = loops_r;
    limit_nx   = limit_r;
    dir_nx     = dir_r;
    wrap_nx    = 1'b0;
    done_nx    = 1'b0;
    clr_s      = 1'b0;
    load_s     = 1'b0;
    en_s       = 1'b0;
    load_val_s = CNT_ZERO;
    case (state_r)
      ST_IDLE: begin
        if (cmd_if.cmd_valid) begin
          limit_nx   = cmd_if.cmd_limit;
          loops_nx   = cmd_if.cmd_loops;
          dir_nx     = cmd_dir_s;
          load_val_s = cmd_dir_s ? cmd_if.cmd_limit : CNT_ZERO;
          if (cmd_if.cmd_loops != LOOP_ZERO) begin
            load_s   = 1'b1;
            state_nx = ST_RUN;
          end else begin
            // zero-loop command completes at once with cnt parked at 0
            clr_s    = 1'b1;
            done_nx  = 1'b1;
            state_nx = ST_DONE;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (abort) begin
          clr_s    = 1'b1;
          loops_nx = LOOP_ZERO;
          state_nx = ST_IDLE;
        end else if (pause) begin
          state_nx = ST_HOLD;
        end else begin
          // HOLD resumes counting on the edge that sees pause low, so a
          // pause sampled high for N cycles delays the run by exactly N
          en_s = 1'b1;
          if (at_term_s) begin
            wrap_nx  = 1'b1;
            loops_nx = loops_r - LOOP_ONE;
            if (loops_r == LOOP_ONE) begin
              // final wrap: park cnt at 0 even when counting down
              clr_s    = 1'b1;
              done_nx  = 1'b1;
              state_nx = ST_DONE;
            end else begin
              state_nx = ST_RUN;
            end
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        clr_s    = 1'b1;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // controller state, latched command and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      loops_r <= LOOP_ZERO;
      limit_r <= CNT_ZERO;
      dir_r   <= 1'b0;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      loops_r <= loops_nx;
      limit_r <= limit_nx;
      dir_r   <= dir_nx;
      wrap_r  <= wrap_nx;
      done_r  <= done_nx;
    end
  end

  mod_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (clr_s),
    .load     (load_s),
    .load_val (load_val_s),
    .en       (en_s),
    .dir      (dir_r),
    .limit    (limit_r),
    .cnt      (cnt),
    .at_term  (at_term_s)
  );

  assign cmd_if.cmd_ready = (state_r == ST_IDLE);
  assign busy             = is_busy(state_r);
  assign wrap             = wrap_r;
  assign done             = done_r;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl
// Scoreboard bench: stimulus pushes timed expectations (per-cycle snapshots
// and wrap/done events); a monitor on the falling edge pops and compares.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pause;
  logic       abort;
  logic [1:0] cnt;
  logic       busy, wrap, done;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct { int c; logic [1:0] v; bit b; bit r; } snap_t;
  typedef struct { int c; bit w; bit d; } ev_t;
  snap_t snapq[$];
  ev_t   evq[$];

  counter_seq_ctrl_if #(.CNT_W(2), .LOOP_W(4)) cmd_if ();

  counter_seq_ctrl #(.CNT_W(2), .LOOP_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd_if (cmd_if),
    .pause  (pause),
    .abort  (abort),
    .cnt    (cnt),
    .busy   (busy),
    .wrap   (wrap),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic snap(input int c, input logic [1:0] v, input bit b, input bit r);
    snap_t s;
    s.c = c; s.v = v; s.b = b; s.r = r;
    snapq.push_back(s);
  endtask

  task automatic ev(input int c, input bit w, input bit d);
    ev_t e;
    e.c = c; e.w = w; e.d = d;
    evq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_cmd(input bit v, input logic [1:0] lim, input logic [3:0] lp);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_limit = lim;
    cmd_if.cmd_loops = lp;
  endtask

  // monitor: event scoreboard on wrap/done, snapshot scoreboard by cycle
  always @(negedge clk) begin
    if (wrap || done) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got wrap=%0b done=%0b expected none", cyc, wrap, done);
      end else begin
        ev_t e;
        e = evq.pop_front();
        if (e.c != cyc || e.w != wrap || e.d != done) begin
          errors++;
          $display("FAIL event cyc=%0d got wrap=%0b done=%0b expected cyc=%0d wrap=%0b done=%0b",
                   cyc, wrap, done, e.c, e.w, e.d);
        end
      end
    end
    while (snapq.size() > 0 && snapq[0].c <= cyc) begin
      snap_t s;
      s = snapq.pop_front();
      checks++;
      if (s.c != cyc || s.v != cnt || s.b != busy || s.r != cmd_if.cmd_ready) begin
        errors++;
        $display("FAIL snapshot cyc=%0d got cnt=%0d busy=%0b ready=%0b expected cyc=%0d cnt=%0d busy=%0b ready=%0b",
                 cyc, cnt, busy, cmd_if.cmd_ready, s.c, s.v, s.b, s.r);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1; pause = 1'b0; abort = 1'b0;
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(3);

    // reset then idle
    rst = 1'b0;
    c0 = cyc;
    for (int i = 1; i <= 3; i++) snap(c0 + i, 2'd0, 1'b0, 1'b1);
    tick(4);

    // limit=3 loops=2, then a second command held through the run
    c0 = cyc;
    drive_cmd(1'b1, 2'd3, 4'd2);
    for (int i = 1; i <= 8; i++) snap(c0 + i, 2'((i - 1) % 4), 1'b1, 1'b0);
    snap(c0 + 9, 2'd0, 1'b0, 1'b0);
    snap(c0 + 10, 2'd0, 1'b0, 1'b1);
    ev(c0 + 5, 1'b1, 1'b0);
    ev(c0 + 9, 1'b1, 1'b1);
    snap(c0 + 11, 2'd0, 1'b1, 1'b0);
    snap(c0 + 12, 2'd1, 1'b1, 1'b0);
    snap(c0 + 13, 2'd0, 1'b0, 1'b0);
    snap(c0 + 14, 2'd0, 1'b0, 1'b1);
    ev(c0 + 13, 1'b1, 1'b1);
    tick(1);
    drive_cmd(1'b1, 2'd1, 4'd1);
    tick(10);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(5);

    // limit=0 loops=3
    c0 = cyc;
    drive_cmd(1'b1, 2'd0, 4'd3);
    for (int i = 1; i <= 3; i++) snap(c0 + i, 2'd0, 1'b1, 1'b0);
    snap(c0 + 4, 2'd0, 1'b0, 1'b0);
    snap(c0 + 5, 2'd0, 1'b0, 1'b1);
    ev(c0 + 2, 1'b1, 1'b0);
    ev(c0 + 3, 1'b1, 1'b0);
    ev(c0 + 4, 1'b1, 1'b1);
    tick(1);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(6);

    // limit=3 loops=1 with pause high for cycles 2..4
    c0 = cyc;
    drive_cmd(1'b1, 2'd3, 4'd1);
    snap(c0 + 1, 2'd0, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) snap(c0 + i, 2'd1, 1'b1, 1'b0);
    snap(c0 + 6, 2'd2, 1'b1, 1'b0);
    snap(c0 + 7, 2'd3, 1'b1, 1'b0);
    snap(c0 + 8, 2'd0, 1'b0, 1'b0);
    snap(c0 + 9, 2'd0, 1'b0, 1'b1);
    ev(c0 + 8, 1'b1, 1'b1);
    tick(1);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(1);
    pause = 1'b1;
    tick(3);
    pause = 1'b0;
    tick(6);

    // limit=3 loops=5 aborted at cycle 3, then a fresh command
    c0 = cyc;
    drive_cmd(1'b1, 2'd3, 4'd5);
    snap(c0 + 1, 2'd0, 1'b1, 1'b0);
    snap(c0 + 2, 2'd1, 1'b1, 1'b0);
    snap(c0 + 3, 2'd2, 1'b1, 1'b0);
    snap(c0 + 4, 2'd0, 1'b0, 1'b1);
    snap(c0 + 5, 2'd0, 1'b0, 1'b1);
    snap(c0 + 6, 2'd0, 1'b1, 1'b0);
    snap(c0 + 7, 2'd1, 1'b1, 1'b0);
    snap(c0 + 8, 2'd0, 1'b0, 1'b0);
    snap(c0 + 9, 2'd0, 1'b0, 1'b1);
    ev(c0 + 8, 1'b1, 1'b1);
    tick(1);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(2);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    drive_cmd(1'b1, 2'd1, 4'd1);
    tick(1);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(5);

    // loops=0 completes immediately without wrap
    c0 = cyc;
    drive_cmd(1'b1, 2'd2, 4'd0);
    snap(c0 + 1, 2'd0, 1'b0, 1'b0);
    snap(c0 + 2, 2'd0, 1'b0, 1'b1);
    ev(c0 + 1, 1'b0, 1'b1);
    tick(1);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(3);

    // reset mid-run
    c0 = cyc;
    drive_cmd(1'b1, 2'd3, 4'd4);
    snap(c0 + 1, 2'd0, 1'b1, 1'b0);
    snap(c0 + 2, 2'd1, 1'b1, 1'b0);
    snap(c0 + 3, 2'd2, 1'b1, 1'b0);
    snap(c0 + 4, 2'd0, 1'b0, 1'b1);
    snap(c0 + 5, 2'd0, 1'b0, 1'b1);
    snap(c0 + 6, 2'd0, 1'b0, 1'b1);
    tick(1);
    drive_cmd(1'b0, 2'd0, 4'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);

    // every expected item must have been consumed
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL events_left got=%0d expected 0", evq.size());
    end
    checks++;
    if (snapq.size() != 0) begin
      errors++;
      $display("FAIL snapshots_left got=%0d expected 0", snapq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
